// File: rtl/adder_serial.sv
`default_nettype none
// ============================================================================
//  Module   : adder_serial
//  Purpose  : Digit-serial adder/subtractor. Adds (sub=0: a+b+c_in) or
//             subtracts (sub=1: a-b) two WIDTH-bit operands DIGIT bits per
//             clock, least-significant digit first. A registered carry links
//             the digits. Valid/ready handshakes on both sides allow
//             backpressure. Reports carry-out and signed overflow.
//  Ports    : clk        - rising-edge clock
//             reset      - asynchronous, active-high reset
//             in_valid   - operand set offered
//             in_ready   - block can accept an operand set (IDLE only)
//             a, b       - WIDTH-bit operands
//             c_in       - carry-in (used only when sub=0)
//             sub        - 0: a+b+c_in, 1: a-b
//             out_valid  - result available (DONE)
//             out_ready  - consumer accepts result
//             sum        - WIDTH-bit result
//             c_out      - carry out of MSB (sub=1: 1 means no borrow)
//             ovf        - two's-complement signed overflow
//  Params   : WIDTH (multiple of DIGIT), DIGIT (1..WIDTH)
//  Revision : 1.0 - initial release
// ============================================================================
module adder_serial #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int c_nstep = WIDTH / DIGIT;
  localparam int c_cnt_w = (c_nstep > 1) ? $clog2(c_nstep) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_nstep - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_carry;
  logic [c_cnt_w-1:0] r_cnt;
  logic [WIDTH-1:0]   r_sum;
  logic               r_c_out;
  logic               r_ovf;

  logic               w_accept;
  logic               w_last;
  logic [DIGIT:0]     w_dsum;
  logic               w_msb_cin;
  logic [31:0]        w_base;
  logic [WIDTH-1:0]   w_a_shift;
  logic [WIDTH-1:0]   w_b_shift;

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        // Held low while reset is asserted so nothing is offered mid-reset.
        in_ready = ~reset;
        if (in_valid && !reset) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (w_last) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign w_accept = in_valid & in_ready;
  assign w_last   = (r_cnt == c_last);

  // --------------------------------------------------------------------------
  // Digit arithmetic
  // --------------------------------------------------------------------------
  assign w_dsum = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]}
                + {{DIGIT{1'b0}}, r_carry};

  // Carry into the top bit of the digit, recovered from that bit's sum.
  // Only meaningful on the final digit, where it is the carry into the MSB.
  assign w_msb_cin = w_dsum[DIGIT-1] ^ r_a[DIGIT-1] ^ r_b[DIGIT-1];

  assign w_base = 32'(r_cnt) * 32'(DIGIT);

  // Operand shift registers: the next digit always sits at the bottom.
  generate
    if (c_nstep > 1) begin : g_multi
      assign w_a_shift = {{DIGIT{1'b0}}, r_a[WIDTH-1:DIGIT]};
      assign w_b_shift = {{DIGIT{1'b0}}, r_b[WIDTH-1:DIGIT]};
    end else begin : g_single
      assign w_a_shift = '0;
      assign w_b_shift = '0;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_c_out <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a     <= a;
            // Subtraction as a + ~b + 1: invert B here, force carry-in to 1.
            r_b     <= b ^ {WIDTH{sub}};
            r_carry <= sub | c_in;
            r_cnt   <= '0;
          end
        end
        RUN: begin
          r_sum[w_base +: DIGIT] <= w_dsum[DIGIT-1:0];
          r_carry <= w_dsum[DIGIT];
          r_a     <= w_a_shift;
          r_b     <= w_b_shift;
          r_cnt   <= r_cnt + 1'b1;
          if (w_last) begin
            r_c_out <= w_dsum[DIGIT];
            r_ovf   <= w_msb_cin ^ w_dsum[DIGIT];
          end
        end
        default: begin
          // DONE: result held stable.
        end
      endcase
    end
  end

  assign sum   = r_sum;
  assign c_out = r_c_out;
  assign ovf   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_adder_serial.sv
`default_nettype none
// ============================================================================
//  Module   : tb_adder_serial
//  Purpose  : Directed self-checking bench for adder_serial. Three instances
//             (DIGIT = 4, 1, 16) share operands; arithmetic vectors run on
//             all three, backpressure and reset-abort run on DIGIT=4.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_adder_serial;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] a, b;
  logic        c_in, sub;
  logic [2:0]  iv, ordy;
  logic [2:0]  ir, ovv, co, of;
  logic [15:0] sm [3];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  adder_serial #(.WIDTH(16), .DIGIT(4)) u_d4 (
    .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(ir[0]),
    .a(a), .b(b), .c_in(c_in), .sub(sub),
    .out_valid(ovv[0]), .out_ready(ordy[0]),
    .sum(sm[0]), .c_out(co[0]), .ovf(of[0])
  );

  adder_serial #(.WIDTH(16), .DIGIT(1)) u_d1 (
    .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(ir[1]),
    .a(a), .b(b), .c_in(c_in), .sub(sub),
    .out_valid(ovv[1]), .out_ready(ordy[1]),
    .sum(sm[1]), .c_out(co[1]), .ovf(of[1])
  );

  adder_serial #(.WIDTH(16), .DIGIT(16)) u_d16 (
    .clk(clk), .reset(reset), .in_valid(iv[2]), .in_ready(ir[2]),
    .a(a), .b(b), .c_in(c_in), .sub(sub),
    .out_valid(ovv[2]), .out_ready(ordy[2]),
    .sum(sm[2]), .c_out(co[2]), .ovf(of[2])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for the DIGIT=4 instance to raise out_valid; n = cycles.
  task automatic wait_v4(output int n);
    n = 0;
    while (!ovv[0] && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  // One operation on all three instances with out_ready held high.
  task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_,
                        input logic tc, input logic ts,
                        input logic [15:0] es, input logic ec, input logic eo);
    int          exp_lat [3] = '{4, 16, 1};
    int          dg      [3] = '{4, 1, 16};
    int          lat     [3] = '{0, 0, 0};
    int          wid     [3] = '{0, 0, 0};
    logic [15:0] rs      [3] = '{16'h0, 16'h0, 16'h0};
    logic        rc      [3] = '{1'b0, 1'b0, 1'b0};
    logic        ro      [3] = '{1'b0, 1'b0, 1'b0};
    logic        ir_after = 1'b0;
    a = ta; b = tb_; c_in = tc; sub = ts;
    iv = 3'b111; ordy = 3'b111;
    @(posedge clk);
    #1;
    iv = 3'b000;
    // Operands must already be captured; scramble the inputs.
    a = 16'hDEAD; b = 16'hBEEF; c_in = ~tc; sub = ~ts;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
        if (ovv[i]) begin
          wid[i]++;
          if (lat[i] == 0) begin
            lat[i] = k;
            rs[i]  = sm[i];
            rc[i]  = co[i];
            ro[i]  = of[i];
          end
        end
      end
      if (lat[0] != 0 && k == lat[0] + 1) ir_after = ir[0];
    end
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_d%0d_lat", tag, dg[i]), lat[i], exp_lat[i]);
      chk($sformatf("%s_d%0d_width", tag, dg[i]), wid[i], 1);
      chk($sformatf("%s_d%0d_sum", tag, dg[i]), {16'h0, rs[i]}, {16'h0, es});
      chk($sformatf("%s_d%0d_cout", tag, dg[i]), {31'h0, rc[i]}, {31'h0, ec});
      chk($sformatf("%s_d%0d_ovf", tag, dg[i]), {31'h0, ro[i]}, {31'h0, eo});
    end
    chk($sformatf("%s_d4_inready_after", tag), {31'h0, ir_after}, 32'h1);
  endtask

  initial begin
    int n;
    int pulses;
    a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
    iv = 3'b000; ordy = 3'b000;
    reset = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("rst_in_ready", {29'h0, ir}, 32'h0);
    chk("rst_out_valid", {29'h0, ovv}, 32'h0);
    chk("rst_sum_d4", {16'h0, sm[0]}, 32'h0);
    chk("rst_sum_d1", {16'h0, sm[1]}, 32'h0);
    chk("rst_sum_d16", {16'h0, sm[2]}, 32'h0);
    chk("rst_flags", {26'h0, co, of}, 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("post_rst_in_ready", {29'h0, ir}, 32'h7);

    // Arithmetic vectors on all three digit widths.
    run_op("add1",  16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    run_op("addc",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("addov", 16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("sub1",  16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op("subov", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // Backpressure on the DIGIT=4 instance.
    a = 16'h1111; b = 16'h2222; c_in = 1'b0; sub = 1'b0;
    iv = 3'b001; ordy = 3'b000;
    @(posedge clk);
    #1;
    iv = 3'b000;
    wait_v4(n);
    chk("bp_lat", n, 4);
    a = 16'h0100; b = 16'h0200;
    iv = 3'b001;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      chk("bp_hold_valid", {31'h0, ovv[0]}, 32'h1);
      chk("bp_hold_sum", {16'h0, sm[0]}, 32'h3333);
      chk("bp_hold_flags", {30'h0, co[0], of[0]}, 32'h0);
      chk("bp_hold_inready", {31'h0, ir[0]}, 32'h0);
    end
    ordy = 3'b001;
    @(posedge clk);
    #1;
    ordy = 3'b000;
    chk("bp_release_valid", {31'h0, ovv[0]}, 32'h0);
    chk("bp_release_inready", {31'h0, ir[0]}, 32'h1);
    chk("bp_release_sum_held", {16'h0, sm[0]}, 32'h3333);
    @(posedge clk);
    #1;
    iv = 3'b000;
    chk("bp_pending_accepted", {31'h0, ir[0]}, 32'h0);
    ordy = 3'b001;
    wait_v4(n);
    chk("bp_next_lat", n, 4);
    chk("bp_next_sum", {16'h0, sm[0]}, 32'h0300);
    @(posedge clk);
    #1;

    // Reset two cycles into RUN.
    a = 16'h00FF; b = 16'h0F0F; c_in = 1'b0; sub = 1'b0;
    iv = 3'b001;
    @(posedge clk);
    #1;
    iv = 3'b000;
    @(posedge clk);
    #1;
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("abort_sum_async", {16'h0, sm[0]}, 32'h0);
    chk("abort_valid_async", {31'h0, ovv[0]}, 32'h0);
    chk("abort_inready_async", {31'h0, ir[0]}, 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("abort_inready_after", {31'h0, ir[0]}, 32'h1);
    pulses = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (ovv[0]) pulses++;
    end
    chk("abort_no_pulse", pulses, 0);
    a = 16'h0001; b = 16'h0001;
    iv = 3'b001;
    @(posedge clk);
    #1;
    iv = 3'b000;
    wait_v4(n);
    chk("abort_next_lat", n, 4);
    chk("abort_next_sum", {16'h0, sm[0]}, 32'h0002);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/adder_serial.md
Name: adder_serial

Overview:
- Multi-cycle, parametrised successor to the single-bit registered full adder.
- Adds or subtracts two WIDTH-bit operands DIGIT bits per clock, ripple-carrying between digits through a registered carry.
- Valid/ready handshakes on input and output let it sit between streaming datapath stages with backpressure.
- Also reports carry-out and signed overflow.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of DIGIT.
- DIGIT, 4, bits processed per clock; NSTEP = WIDTH/DIGIT cycles per operation; 1 <= DIGIT <= WIDTH.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  operand set offered
- in_ready  output  1  block can accept an operand set
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- c_in  input  1  carry-in, used when sub=0
- sub  input  1  0: a+b+c_in; 1: a-b
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result
- c_out  output  1  carry out of MSB (sub=1: 1 = no borrow)
- ovf  output  1  two's-complement signed overflow

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high (reset).
- Reset, asynchronous on assertion:
  - state=IDLE; sum=0, c_out=0, ovf=0, out_valid=0.
  - Digit counter, carry register and operand shift registers cleared.
  - in_ready=0 while reset is high.
- FSM states IDLE, RUN, DONE:
  - IDLE: in_ready=1. Handshake (in_valid & in_ready) at an edge:
    - capture a, b^{WIDTH{sub}}, sub, c_in;
    - carry register = sub ? 1 : c_in;
    - counter=0; go to RUN.
  - RUN: in_ready=0, out_valid=0. Each cycle:
    - add the lowest remaining DIGIT bits of A and B' plus the carry register;
    - write the DIGIT-bit result into sum at bits [counter*DIGIT +: DIGIT], LSB digit first;
    - update the carry register; counter++.
  - RUN, final digit (counter=NSTEP-1): c_out = carry out of bit WIDTH-1; ovf = carry into MSB XOR carry out of MSB. Go to DONE.
  - DONE: out_valid=1; sum/c_out/ovf held stable. On out_ready=1 at an edge, go to IDLE. in_valid is ignored in RUN and DONE.
- Latency and throughput:
  - Input handshake edge → out_valid high NSTEP cycles later (rising at edge NSTEP+1 counted from the accept edge as edge 1).
  - Minimum issue interval NSTEP+2 cycles: accept, NSTEP RUN cycles, DONE, return to IDLE.
- Intermediate values and hold:
  - sum may show partially written digits during RUN; consumers sample only under out_valid.
  - After DONE→IDLE, sum/c_out/ovf retain the last result until the next operation's first RUN cycle.
- out_ready already high on DONE entry → out_valid high for exactly one cycle.
- Operands are captured at accept; input changes during RUN/DONE have no effect.
- Arithmetic is modulo 2^WIDTH. c_in is ignored when sub=1.
- Reset asserted in any state (including mid-RUN or in DONE with out_valid high):
  - immediate return to the reset values above; the in-flight operation is discarded;
  - no out_valid pulse follows deassertion.
- DIGIT=WIDTH degenerates to NSTEP=1: single RUN cycle.

Test Plan:
- WIDTH=16, DIGIT=4; a=0x1234, b=0x4321, c_in=0, sub=0, out_ready=1 → out_valid 4 cycles after accept, one cycle wide; sum=0x5555, c_out=0, ovf=0; in_ready back to 1 the next cycle.
- a=0xFFFF, b=0x0001, c_in=0 → sum=0x0000, c_out=1, ovf=0. Then a=0x7FFF, b=0x0000, c_in=1 → sum=0x8000, c_out=0, ovf=1 (carry ripples across all 4 digits).
- sub=1, a=0x0005, b=0x0007, c_in=1 → sum=0xFFFE, c_out=0, ovf=0; then a=0x8000, b=0x0001 → sum=0x7FFF, c_out=1, ovf=1.
- Backpressure: out_ready=0 for 6 cycles after out_valid rises → out_valid, sum and flags stable; in_ready=0; a new in_valid with different operands is not accepted. Raise out_ready → one transfer, IDLE next cycle, then the pending input is accepted.
- Assert reset 2 cycles into RUN → outputs cleared asynchronously (before the next clk edge); after deassertion in_ready=1, out_valid never pulses for the aborted operation; the next operation a=0x0001, b=0x0001 gives sum=0x0002.
- Re-run scenarios 1–3 with DIGIT=1 (latency 16) and DIGIT=16 (latency 1) → identical sum/c_out/ovf values.
